mbist_march_ctrl: RTL and testbench
===================================

# mbist_march_ctrl

March C- memory BIST sequencer that drives address, data and read/write strobes into a single-port synchronous SRAM and checks every read against the expected background. Mismatches are reported per read as a fail_valid pulse with the failing address, which the MBISR repair logic consumes. The block sits between the chip-level start/done/fail pins and the memory under test. It replaces ad-hoc test sequencing inside the top level.

## Interface
- ADDR_W, 4: memory address width; N = 2^ADDR_W words.
- DATA_W, 8: memory word width; background 0 = all zeros, background 1 = all ones.

- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level; sampled in IDLE and DONE only.
- mem_addr  out  ADDR_W  registered memory address.
- mem_wdata  out  DATA_W  registered write data.
- mem_we  out  1  registered write strobe.
- mem_re  out  1  registered read strobe.
- mem_rdata  in  DATA_W  read data, valid in the cycle after the memory samples mem_re (1-cycle latency).
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE.
- fail  out  1  sticky; set on any mismatch, cleared on start.
- fail_valid  out  1  one-cycle pulse per mismatching read.
- fail_addr  out  ADDR_W  address of the latest mismatch; holds its value between pulses.
- fail_count  out  4  mismatch count, saturates at 15.

## Operation
- Reset value of all outputs is 0, and the state is IDLE.
- States and transitions:
  - IDLE → RUN on start=1.
  - RUN → DRAIN after the last op.
  - DRAIN → DONE.
  - DONE → RUN on start=1.
  - Otherwise each state holds.
- Leaving IDLE or DONE for RUN clears fail, fail_count and fail_addr.
- March C- element table, executed in order. Within an element the ops run per address, in the listed order:
  - M0: any order (up), w0
  - M1: up, r0, w1
  - M2: up, r1, w0
  - M3: down, r0, w1
  - M4: down, r1, w0
  - M5: up, r0
- The sequence is 10N ops total, one op per cycle, with no idle cycles between elements.
- In a write op: mem_we=1, mem_re=0, and mem_wdata holds the background.
- In a read op: mem_re=1, mem_we=0, and mem_wdata=0.
- Address counter behaviour:
  - Up counts 0→N-1; down counts N-1→0.
  - The counter reloads at each element boundary.
  - Wrap-around is never used to step between elements.
- Read check pipeline:
  - The read address and expected value are carried through a 2-stage pipe aligned with the memory latency.
  - mem_rdata is compared with the expected value in the cycle it is valid.
  - The comparison result is registered into fail, fail_valid, fail_addr and fail_count.
- start is ignored in RUN and DRAIN.
- In DONE, done is held until start restarts the test.
- In DRAIN, all mem strobes are 0.

## Timing
- Reference point: edge 0 is the edge that samples start=1.
- Op i (i = 0..10N-1) is driven on the mem_* outputs during the cycle after edge i.
- A read driven after edge i is sampled by the memory at edge i+1, and mem_rdata is valid after edge i+1.
- The resulting fail_valid / fail_addr / fail_count update is visible after edge i+2.
- DRAIN occupies the cycle after edge 10N.
- done rises after edge 10N+1, which is 161 for N=16.
- The last M5 mismatch pulse coincides with the rise of done.
- fail rises in the same cycle as the first fail_valid.
- fail_count at 15 stays at 15, and fail_valid still pulses.
- rst during any state takes priority over everything else:
  - All outputs read 0 after that edge.
  - In-flight pipeline entries are discarded, so no fail_valid appears afterwards.

## Structure
- mbist_pkg holds the state enum {IDLE, RUN, DRAIN, DONE}, the op enum {W0, W1, R0, R1} and the direction enum {UP, DOWN}.
- mbist_pkg also holds the localparam March C- table: per element the direction, op count and op list.
- One sub-module, mbist_addr_gen:
  - Loadable up/down counter with a last-address flag.
  - Parameterised by ADDR_W.
- The controller FSM, the op index within the element, the element index and the check pipe stay in mbist_march_ctrl.

## Test plan
- Fault-free memory model, N=16, start pulsed for 1 cycle:
  - done rises 161 edges after the start edge.
  - busy is high for 161 cycles.
  - fail=0, fail_count=0, with 160 mem ops observed.
- Stuck-at-0 on bit 3 of address 5:
  - Exactly 2 fail_valid pulses, in M2 r1 and M4 r1.
  - fail_addr=5 each time; fail_count=2; fail=1 at done.
- Stuck-at-1 on bit 0 of address 15:
  - 3 pulses, in M1, M3 and M5.
  - The first pulse appears 2 cycles after the M1 read of address 15.
  - fail_count=3.
- Every word stuck at 0x00:
  - fail_count saturates at 15.
  - fail_valid keeps pulsing, 32 pulses in total.
- rst asserted at cycle 50 of RUN:
  - All outputs are 0 on the next cycle.
  - No fail_valid follows.
  - A subsequent start runs the full 161-edge sequence.
- start held high through RUN, then pulsed in DONE after a failing run:
  - Holding start in RUN has no effect.
  - The DONE-state pulse clears fail and fail_count and restarts from M0, address 0.

Source files
------------

// File: rtl/mbist_pkg.sv
// Shared types and the March C- element table for the memory BIST sequencer.
package mbist_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    // bit 1 = read, bit 0 = background value
    typedef enum logic [1:0] {W0 = 2'b00, W1 = 2'b01, R0 = 2'b10, R1 = 2'b11} op_e;

    typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_e;

    typedef struct packed {
        dir_e       dir;
        logic [1:0] n_ops;
        op_e        op0;
        op_e        op1;
    } elem_t;

    localparam int         NUM_ELEM  = 6;
    localparam logic [2:0] LAST_ELEM = 3'd5;

    localparam elem_t MARCH_TBL [NUM_ELEM] = '{
        '{UP,   2'd1, W0, W0},
        '{UP,   2'd2, R0, W1},
        '{UP,   2'd2, R1, W0},
        '{DOWN, 2'd2, R0, W1},
        '{DOWN, 2'd2, R1, W0},
        '{UP,   2'd1, R0, R0}
    };

endpackage

// File: rtl/mbist_march_ctrl_addr_gen.sv
// Loadable up/down address counter; the counter value is the registered memory address.
module mbist_addr_gen
    import mbist_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  dir_e              dir,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    dir_e dir_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr  <= '0;
            dir_q <= UP;
        end else if (load) begin
            addr  <= (dir == UP) ? '0 : '1;
            dir_q <= dir;
        end else if (step) begin
            addr  <= (dir_q == UP) ? addr + 1'b1 : addr - 1'b1;
        end
    end

    assign last = (dir_q == UP) ? (&addr) : ~(|addr);

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- BIST sequencer: issues one memory op per cycle and checks reads
// through a two-stage pipe matched to the 1-cycle SRAM read latency.
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic              fail_valid,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [3:0]        fail_count
);

    state_e     state_q, state_d;
    logic [2:0] elem_q, elem_d;
    logic       opi_q, opi_d;
    logic       ag_load, ag_step, addr_last;
    logic       issue, clr, last_op, last_opi;
    elem_t      cur, nxt;
    op_e        op_d;

    // elem_q/opi_q describe the op currently on the mem_* outputs
    assign cur      = MARCH_TBL[elem_q];
    assign last_opi = ({1'b0, opi_q} == cur.n_ops - 2'd1);
    assign last_op  = (elem_q == LAST_ELEM) && addr_last && last_opi;
    assign nxt      = MARCH_TBL[elem_d];
    assign op_d     = opi_d ? nxt.op1 : nxt.op0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            elem_q  <= '0;
            opi_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            opi_q   <= opi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        opi_d   = opi_q;
        ag_load = 1'b0;
        ag_step = 1'b0;
        issue   = 1'b0;
        clr     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    elem_d  = '0;
                    opi_d   = 1'b0;
                    ag_load = 1'b1;
                    issue   = 1'b1;
                    clr     = 1'b1;
                end
            end
            RUN: begin
                if (last_op) begin
                    state_d = DRAIN;
                end else begin
                    issue = 1'b1;
                    if (!last_opi) begin
                        opi_d = 1'b1;
                    end else if (!addr_last) begin
                        opi_d   = 1'b0;
                        ag_step = 1'b1;
                    end else begin
                        elem_d  = elem_q + 3'd1;
                        opi_d   = 1'b0;
                        ag_load = 1'b1;
                    end
                end
            end
            DRAIN:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    mbist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk  (clk),
        .rst  (rst),
        .load (ag_load),
        .step (ag_step),
        .dir  (nxt.dir),
        .addr (mem_addr),
        .last (addr_last)
    );

    // stage 0 travels with mem_re, stage 1 lines up with mem_rdata
    logic [1:0]        vld_pipe;
    logic [1:0]        exp_pipe;
    logic [ADDR_W-1:0] chk_addr;
    logic              mismatch;

    assign mismatch = vld_pipe[1] && (mem_rdata != {DATA_W{exp_pipe[1]}});

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            vld_pipe   <= '0;
            exp_pipe   <= '0;
            chk_addr   <= '0;
            fail       <= 1'b0;
            fail_valid <= 1'b0;
            fail_addr  <= '0;
            fail_count <= '0;
        end else begin
            mem_we      <= issue && !op_d[1];
            mem_re      <= issue && op_d[1];
            mem_wdata   <= (issue && !op_d[1]) ? {DATA_W{op_d[0]}} : '0;
            busy        <= (state_d == RUN) || (state_d == DRAIN);
            done        <= (state_d == DONE);
            vld_pipe[0] <= issue && op_d[1];
            exp_pipe[0] <= op_d[0];
            vld_pipe[1] <= vld_pipe[0];
            exp_pipe[1] <= exp_pipe[0];
            chk_addr    <= mem_addr;
            fail_valid  <= mismatch;
            if (clr) begin
                fail       <= 1'b0;
                fail_addr  <= '0;
                fail_count <= '0;
            end else if (mismatch) begin
                fail      <= 1'b1;
                fail_addr <= chk_addr;
                if (fail_count != 4'hF) fail_count <= fail_count + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Directed bench for mbist_march_ctrl with a faultable 16x8 SRAM model.
module tb_mbist_march_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we, mem_re;
    logic [7:0] mem_rdata = 8'h00;
    logic       busy, done, fail, fail_valid;
    logic [3:0] fail_addr, fail_count;

    int checks = 0;
    int errors = 0;

    mbist_march_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .busy(busy), .done(done), .fail(fail),
        .fail_valid(fail_valid), .fail_addr(fail_addr), .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [16];
    int         sa0_a = -1, sa1_a = -1;
    logic [7:0] sa0_m = 8'h00, sa1_m = 8'h00;
    bit         allz = 1'b0;

    function automatic logic [7:0] rd_val(input logic [3:0] a);
        logic [7:0] v;
        v = mem[a];
        if (allz) return 8'h00;
        if (int'(a) == sa0_a) v = v & ~sa0_m;
        if (int'(a) == sa1_a) v = v | sa1_m;
        return v;
    endfunction

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= rd_val(mem_addr);
    end

    // {addr, we, re, wdata} expected during the cycle after edge i
    function automatic logic [13:0] exp_op(input int i);
        int j, e, pos;
        logic [3:0] a;
        if (i < 16) return {4'(i), 2'b10, 8'h00};
        j = i - 16;
        if (j >= 128) return {4'(j - 128), 2'b01, 8'h00};
        e   = 1 + j / 32;
        pos = (j % 32) / 2;
        a   = (e >= 3) ? 4'(15 - pos) : 4'(pos);
        if (j % 2 == 0) return {a, 2'b01, 8'h00};
        return {a, 2'b10, (e == 1 || e == 3) ? 8'hFF : 8'h00};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    int done_edge, busy_cyc, op_cnt, op_err, pulse_cnt, first_pe, last_pe;
    int s0_fail, s0_cnt, s0_faddr;

    task automatic run_test(input bit hold);
        done_edge = -1; busy_cyc = 0; op_cnt = 0; op_err = 0;
        pulse_cnt = 0; first_pe = -1; last_pe = -1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (k == 0) begin
                s0_fail = int'(fail); s0_cnt = int'(fail_count); s0_faddr = int'(fail_addr);
            end
            if (busy) busy_cyc++;
            if (mem_we || mem_re) op_cnt++;
            if (k < 160 && {mem_addr, mem_we, mem_re, mem_wdata} !== exp_op(k)) op_err++;
            if (fail_valid) begin
                pulse_cnt++;
                if (first_pe < 0) first_pe = k;
                last_pe = k;
            end
            if (done) begin
                done_edge = k;
                start = 1'b0;
                break;
            end
            if (!hold) start = 1'b0;
        end
        start = 1'b0;
    endtask

    typedef struct {
        int sa0_a; logic [7:0] sa0_m; int sa1_a; logic [7:0] sa1_m; bit allz; bit hold;
        int pulses; int cnt; int fl; int faddr; int first_pe; int last_pe;
    } vec_t;

    vec_t tbl [5];
    int   nfv;

    initial begin
        tbl[0] = '{-1, 8'h00, -1, 8'h00, 1'b0, 1'b0,  0,  0, 0,  0, -1,  -1};
        tbl[1] = '{ 5, 8'h08, -1, 8'h00, 1'b0, 1'b0,  2,  2, 1,  5, 60, 134};
        tbl[2] = '{-1, 8'h00, 15, 8'h01, 1'b0, 1'b0,  3,  3, 1, 15, 48, 161};
        tbl[3] = '{-1, 8'h00, -1, 8'h00, 1'b1, 1'b0, 32, 15, 1,  0, 50, 144};
        tbl[4] = '{ 5, 8'h08, -1, 8'h00, 1'b0, 1'b1,  2,  2, 1,  5, 60, 134};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", int'({mem_addr, mem_wdata, mem_we, mem_re, busy, done,
                                   fail, fail_valid, fail_addr, fail_count}), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_no_start_busy", int'(busy), 0);

        for (int v = 0; v < 5; v++) begin
            sa0_a = tbl[v].sa0_a; sa0_m = tbl[v].sa0_m;
            sa1_a = tbl[v].sa1_a; sa1_m = tbl[v].sa1_m; allz = tbl[v].allz;
            run_test(tbl[v].hold);
            chk($sformatf("v%0d_done_edge", v), done_edge, 161);
            chk($sformatf("v%0d_busy_cycles", v), busy_cyc, 161);
            chk($sformatf("v%0d_op_count", v), op_cnt, 160);
            chk($sformatf("v%0d_op_seq_errs", v), op_err, 0);
            chk($sformatf("v%0d_pulses", v), pulse_cnt, tbl[v].pulses);
            chk($sformatf("v%0d_fail_count", v), int'(fail_count), tbl[v].cnt);
            chk($sformatf("v%0d_fail", v), int'(fail), tbl[v].fl);
            chk($sformatf("v%0d_fail_addr", v), int'(fail_addr), tbl[v].faddr);
            chk($sformatf("v%0d_first_pulse", v), first_pe, tbl[v].first_pe);
            chk($sformatf("v%0d_last_pulse", v), last_pe, tbl[v].last_pe);
        end

        // still in DONE after the held-start failing run; done must hold
        repeat (3) @(negedge clk);
        chk("done_held", int'(done), 1);
        chk("done_fail_kept", int'(fail), 1);
        sa0_a = -1; sa0_m = 8'h00;
        run_test(1'b0);
        chk("restart_fail_clr", s0_fail, 0);
        chk("restart_cnt_clr", s0_cnt, 0);
        chk("restart_faddr_clr", s0_faddr, 0);
        chk("restart_op_seq", op_err, 0);
        chk("restart_done_edge", done_edge, 161);
        chk("restart_fail_end", int'(fail), 0);

        // reset in the middle of M2 with reads still in flight
        allz = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 50; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre_reset_fail", int'(fail), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_reset_outputs", int'({mem_addr, mem_wdata, mem_we, mem_re, busy, done,
                                       fail, fail_valid, fail_addr, fail_count}), 0);
        rst = 1'b0;
        nfv = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (fail_valid || busy) nfv++;
        end
        chk("post_reset_quiet", nfv, 0);
        allz = 1'b0;
        run_test(1'b0);
        chk("post_reset_done_edge", done_edge, 161);
        chk("post_reset_busy", busy_cyc, 161);
        chk("post_reset_pulses", pulse_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
